cache_trace_delta_encoder: RTL and testbench
============================================

// Module: cache_trace_delta_encoder
// PURPOSE
//  Streaming encoder for cache access traces: takes absolute access addresses (valid/ready), emits the
//  signed delta from the previous address as a zigzag + LEB128-style varint byte stream (valid/ready).
//  Sits between the cache front end and the trace capture buffer. The decoder reconstructs
//  addr[0]=delta[0], addr[i]=addr[i-1]+delta[i].
// PARAMETERS
//  ADDR_W   32   address width in bits; all delta arithmetic is modulo 2^ADDR_W
//  CNT_W    32   width of the record and byte statistics counters
// PORTS
//  clk         in   1        clock, all state on rising edge
//  rst         in   1        synchronous, active-high reset
//  in_valid    in   1        in_addr holds a new access address
//  in_ready    out  1        encoder accepts in_addr this cycle
//  in_addr     in   ADDR_W   absolute access address
//  restart     in   1        sampled with an accepted input; treat prev address as 0 (absolute record)
//  out_valid   out  1        out_byte valid
//  out_ready   in   1        downstream accepts out_byte this cycle
//  out_byte    out  8        encoded byte; bit7=1 means more bytes follow
//  out_last    out  1        out_byte is the final byte of the current record
//  rec_count   out  CNT_W    records fully emitted (wraps)
//  byte_count  out  CNT_W    bytes emitted (wraps)
// BEHAVIOUR
//  - Reset: out_valid=0, out_byte=0, out_last=0, rec_count=0, byte_count=0, prev_addr=0, state IDLE;
//    in_ready=1 in the first cycle after reset. A mid-record reset drops the record.
//  - Accept: in_valid && in_ready. Capture d = in_addr - (restart ? 0 : prev_addr), mod 2^ADDR_W,
//    read as signed. prev_addr <= in_addr.
//  - Zigzag: z = (d << 1) ^ {ADDR_W{d[ADDR_W-1]}}. Unsigned ADDR_W bits.
//  - Varint: N = max(1, ceil(msb_pos(z)+1 / 7)), 1..ceil(ADDR_W/7) bytes, LSB group first.
//    Byte k = {k<N-1, z[7k+6:7k]}, with z zero-extended above ADDR_W.
//  - Latency: first byte valid in the cycle after accept (registered). Then one byte per cycle while
//    out_ready=1.
//  - FSM: IDLE (out_valid=0, in_ready=1) -> EMIT on accept. EMIT: hold out_byte/out_last stable
//    while out_ready=0. On out_valid&&out_ready, advance: shift z right 7, decrement remaining.
//    On the last byte, go to IDLE, or reload EMIT directly if an input is accepted in the same cycle.
//  - in_ready = (state==IDLE) || (out_valid && out_ready && out_last). Back-to-back records need no
//    bubble. The combinational path out_ready->in_ready is allowed.
//  - Counters: byte_count+1 on every out handshake; rec_count+1 on a handshake with out_last=1.
//    Both wrap at 2^CNT_W.
//  - First record after reset: prev_addr=0, so delta = absolute address.
// STRUCTURE
//  - cache_trace_pkg: ADDR_W default, MAX_BYTES = (ADDR_W+6)/7, state enum {IDLE, EMIT},
//    function varint_len(z).
//  - One sub-module, trace_zigzag: combinational d -> z plus byte count N. The top module holds
//    the FSM, shift register, prev_addr and counters.
// TESTING
//  1. After reset, 0x100 -> bytes 0x80,0x04 (last on 2nd); rec_count=1, byte_count=2.
//  2. Then 0x120 -> 0x40 (last); then 0x100 -> 0x3F (d=-32); then 0x100 again -> 0x00 (d=0).
//  3. prev 0x100, addr 0x0 -> 0xFF,0x03. prev 0, addr 0x80000000 -> FF FF FF FF 0F (5 bytes, MAX_BYTES).
//  4. Hold out_ready=0 3 cycles mid-record -> out_byte/out_last stable, in_ready=0, no counter change.
//  5. in_valid held high, out_ready=1, 1-byte deltas -> one byte per cycle, in_ready pulses on each
//     last byte, no idle cycle.
//  6. restart=1 with addr 0x40 after prev 0x1000 -> 0x80,0x01. rst mid-record -> out_valid=0 next cycle,
//     counters 0, next addr encoded absolute.

Source files
------------

// File: rtl/cache_trace_pkg.sv
// Shared definitions for the cache trace delta encoder.
//   ADDR_W_DEF : default address width
//   MAX_BYTES  : longest varint record for ADDR_W_DEF bits
//   LEN_W      : width of a varint byte count (enough for up to 64-bit values)
//   state_t    : encoder FSM states
//   varint_len : number of 7-bit groups needed for a value (at least 1)
package cache_trace_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int MAX_BYTES  = (ADDR_W_DEF + 6) / 7;
  localparam int LEN_W      = 4;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  // Highest non-empty 7-bit group decides the length; zero still costs one byte.
  function automatic logic [LEN_W-1:0] varint_len(input logic [63:0] z);
    logic [LEN_W-1:0] n;
    n = LEN_W'(1);
    for (int k = 1; k < 10; k++) begin
      if ((z >> (7 * k)) != 64'd0) begin
        n = LEN_W'(k + 1);
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/trace_zigzag.sv
// Combinational zigzag mapping of a signed delta plus its varint byte count.
//   d      : delta, two's complement, ADDR_W bits
//   z      : zigzag value (d << 1) ^ sign-fill
//   nbytes : varint length of z in bytes (1..ceil(ADDR_W/7))
// ADDR_W must lie in 2..63 so z fits the 64-bit length helper.
import cache_trace_pkg::*;

module trace_zigzag #(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic [ADDR_W-1:0] d,
  output logic [ADDR_W-1:0] z,
  output logic [LEN_W-1:0]  nbytes
);

  // Bit 0 receives the sign alone since the shifted-in bit is zero.
  for (genvar gi = 0; gi < ADDR_W; gi++) begin : g_zz
    if (gi == 0) begin : g_lsb
      assign z[gi] = d[ADDR_W-1];
    end else begin : g_up
      assign z[gi] = d[gi-1] ^ d[ADDR_W-1];
    end
  end

  assign nbytes = varint_len(64'(z));

endmodule

// File: rtl/cache_trace_delta_encoder.sv
// Streaming cache-trace encoder: absolute addresses in, zigzag/varint deltas out.
//   clk, rst              : clock, synchronous active-high reset
//   in_valid/in_ready     : address handshake; in_addr, restart sampled on accept
//   out_valid/out_ready   : byte handshake; out_byte bit7 = continuation, out_last ends record
//   rec_count, byte_count : wrapping counts of emitted records and bytes
import cache_trace_pkg::*;

module cache_trace_delta_encoder #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic              restart,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_byte,
  output logic              out_last,
  output logic [CNT_W-1:0]  rec_count,
  output logic [CNT_W-1:0]  byte_count
);

  localparam int MAX_B = (ADDR_W + 6) / 7;
  localparam int SH_W  = 7 * MAX_B;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] prev_addr_reg, prev_addr_next;
  logic [SH_W-1:0]   shift_reg, shift_next;
  logic [LEN_W-1:0]  remain_reg, remain_next;   // bytes still to come after out_byte
  logic [7:0]        byte_reg, byte_next;
  logic              last_reg, last_next;
  logic [CNT_W-1:0]  rec_reg, rec_next;
  logic [CNT_W-1:0]  bcnt_reg, bcnt_next;

  logic [ADDR_W-1:0] delta;
  logic [ADDR_W-1:0] zz;
  logic [LEN_W-1:0]  zz_len;
  logic [SH_W-1:0]   zz_ext;
  logic              out_fire;
  logic              in_fire;

  assign out_valid  = (state_reg == EMIT);
  assign out_fire   = out_valid && out_ready;
  // Accept while the final byte leaves so consecutive records have no gap.
  assign in_ready   = (state_reg == IDLE) || (out_fire && last_reg);
  assign in_fire    = in_valid && in_ready;

  assign out_byte   = byte_reg;
  assign out_last   = last_reg;
  assign rec_count  = rec_reg;
  assign byte_count = bcnt_reg;

  assign delta  = in_addr - (restart ? '0 : prev_addr_reg);
  assign zz_ext = SH_W'(zz);

  trace_zigzag #(.ADDR_W(ADDR_W)) u_zigzag (
    .d      (delta),
    .z      (zz),
    .nbytes (zz_len)
  );

  always_comb begin
    state_next     = state_reg;
    prev_addr_next = prev_addr_reg;
    shift_next     = shift_reg;
    remain_next    = remain_reg;
    byte_next      = byte_reg;
    last_next      = last_reg;
    rec_next       = rec_reg;
    bcnt_next      = bcnt_reg;

    if (out_fire) begin
      bcnt_next = bcnt_reg + CNT_W'(1);
      if (last_reg) begin
        rec_next   = rec_reg + CNT_W'(1);
        state_next = IDLE;
      end else begin
        byte_next   = {remain_reg > LEN_W'(1), shift_reg[6:0]};
        last_next   = (remain_reg == LEN_W'(1));
        shift_next  = shift_reg >> 7;
        remain_next = remain_reg - LEN_W'(1);
      end
    end

    // A new record overrides the IDLE transition taken on its predecessor's last byte.
    if (in_fire) begin
      state_next     = EMIT;
      prev_addr_next = in_addr;
      byte_next      = {zz_len > LEN_W'(1), zz_ext[6:0]};
      last_next      = (zz_len == LEN_W'(1));
      shift_next     = zz_ext >> 7;
      remain_next    = zz_len - LEN_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      prev_addr_reg <= '0;
      shift_reg     <= '0;
      remain_reg    <= '0;
      byte_reg      <= '0;
      last_reg      <= 1'b0;
      rec_reg       <= '0;
      bcnt_reg      <= '0;
    end else begin
      state_reg     <= state_next;
      prev_addr_reg <= prev_addr_next;
      shift_reg     <= shift_next;
      remain_reg    <= remain_next;
      byte_reg      <= byte_next;
      last_reg      <= last_next;
      rec_reg       <= rec_next;
      bcnt_reg      <= bcnt_next;
    end
  end

endmodule

// File: tb/tb_cache_trace_delta_encoder.sv
// Bench for cache_trace_delta_encoder: a queue-based reference model checked every
// negative clock edge, plus directed records with literal expected byte lists.
module tb_cache_trace_delta_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_addr;
  logic        restart;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_byte;
  logic        out_last;
  logic [31:0] rec_count;
  logic [31:0] byte_count;

  cache_trace_delta_encoder #(.ADDR_W(32), .CNT_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_addr    (in_addr),
    .restart    (restart),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_byte   (out_byte),
    .out_last   (out_last),
    .rec_count  (rec_count),
    .byte_count (byte_count)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  // Reference model state
  logic [7:0]  mq[$];       // bytes of the record currently being emitted
  logic [31:0] m_prev = 32'd0;
  logic [31:0] m_rec = 32'd0;
  logic [31:0] m_bytes = 32'd0;
  bit          m_live = 1'b0;
  bit          m_after_rst = 1'b0;
  logic [7:0]  got[$];      // bytes the model saw handshaken
  int          acc_cnt = 0;
  int          last_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Signed delta -> zigzag by arithmetic, then 7-bit groups LSB first.
  function automatic void push_record(input logic [31:0] d32);
    longint sd;
    longint unsigned z;
    logic [7:0] b;
    sd = longint'($signed(d32));
    z  = (sd >= 0) ? longint'(2 * sd) : longint'(-2 * sd - 1);
    do begin
      b = {1'b0, z[6:0]};
      z = z >> 7;
      if (z != 0) b[7] = 1'b1;
      mq.push_back(b);
    end while (z != 0);
  endfunction

  always @(negedge clk) begin
    bit exp_ready;
    bit acc;
    bit fire;
    if (m_live) begin
      exp_ready = (mq.size() == 0) || (mq.size() == 1 && out_ready);
      check("out_valid", out_valid, mq.size() != 0);
      if (mq.size() != 0) begin
        check("out_byte", out_byte, mq[0]);
        check("out_last", out_last, mq.size() == 1);
      end
      if (m_after_rst) begin
        check("rst_out_byte", out_byte, 0);
        check("rst_out_last", out_last, 0);
      end
      check("in_ready", in_ready, exp_ready);
      check("rec_count", rec_count, m_rec);
      check("byte_count", byte_count, m_bytes);
    end
    if (rst) begin
      mq.delete();
      m_prev = 32'd0;
      m_rec = 32'd0;
      m_bytes = 32'd0;
      m_live = 1'b1;
      m_after_rst = 1'b1;
    end else if (m_live) begin
      m_after_rst = 1'b0;
      exp_ready = (mq.size() == 0) || (mq.size() == 1 && out_ready);
      fire = (mq.size() != 0) && out_ready;
      acc  = in_valid && exp_ready;
      if (fire) begin
        got.push_back(mq[0]);
        m_bytes++;
        if (mq.size() == 1) begin
          m_rec++;
          last_cnt++;
        end
        void'(mq.pop_front());
      end
      if (acc) begin
        push_record(in_addr - (restart ? 32'd0 : m_prev));
        m_prev = in_addr;
        acc_cnt++;
      end
    end
  end

  task automatic send(input logic [31:0] a, input bit rs);
    int base;
    int i;
    base = acc_cnt;
    in_valid = 1'b1;
    in_addr = a;
    restart = rs;
    for (i = 0; i < 50 && acc_cnt == base; i++) begin
      @(posedge clk);
      #1;
    end
    check("accept_timeout", acc_cnt != base, 1);
    in_valid = 1'b0;
    restart = 1'b0;
  endtask

  task automatic wait_done(input int lb);
    for (int i = 0; i < 50 && last_cnt == lb; i++) begin
      @(posedge clk);
      #1;
    end
    check("record_timeout", last_cnt != lb, 1);
  endtask

  task automatic check_got(input string name, input int n, input logic [39:0] exp);
    check({name, "_len"}, got.size(), n);
    for (int k = 0; k < n && k < got.size(); k++) begin
      check({name, "_byte"}, got[k], exp[8*k +: 8]);
    end
  endtask

  task automatic run_rec(input string name, input logic [31:0] a, input bit rs,
                         input int n, input logic [39:0] exp);
    int lb;
    lb = last_cnt;
    got.delete();
    send(a, rs);
    wait_done(lb);
    check_got(name, n, exp);
    $display("record %s addr=%08h restart=%0d bytes=%0d", name, a, rs, got.size());
  endtask

  initial begin
    int lb;
    int ab;
    int idx;
    int iter;
    rst = 1'b1;
    in_valid = 1'b0;
    in_addr = 32'd0;
    restart = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);

    // Absolute first record, then small positive/negative/zero deltas
    run_rec("abs_0x100", 32'h100, 1'b0, 2, 40'h04_80);
    check("t1_rec_count", rec_count, 1);
    check("t1_byte_count", byte_count, 2);
    run_rec("plus32", 32'h120, 1'b0, 1, 40'h40);
    run_rec("minus32", 32'h100, 1'b0, 1, 40'h3F);
    run_rec("zero", 32'h100, 1'b0, 1, 40'h00);
    run_rec("minus256", 32'h0, 1'b0, 2, 40'h03_FF);

    // Longest record with a 3-cycle stall after its first byte
    out_ready = 1'b0;
    lb = last_cnt;
    got.delete();
    send(32'h8000_0000, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check("stall_byte", out_byte, 8'hFF);
      check("stall_last", out_last, 0);
      check("stall_in_ready", in_ready, 0);
      check("stall_byte_count", byte_count, 7);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    wait_done(lb);
    check_got("min_int", 5, 40'h0F_FF_FF_FF_FF);
    check("t4_rec_count", rec_count, 6);
    check("t4_byte_count", byte_count, 12);
    $display("record min_int addr=80000000 stalled bytes=%0d", got.size());

    // Back-to-back single-byte records with in_valid held high
    lb = last_cnt;
    ab = acc_cnt;
    got.delete();
    in_valid = 1'b1;
    in_addr = 32'd1;
    restart = 1'b1;
    idx = 0;
    iter = 0;
    while (idx < 4 && iter < 50) begin
      @(posedge clk);
      #1;
      iter++;
      if (acc_cnt != ab) begin
        ab = acc_cnt;
        idx++;
        restart = 1'b0;
        in_addr = 32'(idx + 1);
        if (idx == 4) in_valid = 1'b0;
      end
    end
    wait_done(lb + 3);
    check("stream_accept_cycles", iter, 4);
    check_got("stream", 4, 40'h02_02_02_02);
    $display("record stream four 1-byte records in %0d cycles", iter);

    // Restart forces an absolute record
    run_rec("to_0x1000", 32'h1000, 1'b0, 2, 40'h3F_F8);
    run_rec("restart_0x40", 32'h40, 1'b1, 2, 40'h01_80);

    // Reset in the middle of a record drops it
    send(32'h8000_0000, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_rec_count", rec_count, 0);
    check("midrst_byte_count", byte_count, 0);
    check("midrst_in_ready", in_ready, 1);
    run_rec("after_rst_0x100", 32'h100, 1'b0, 2, 40'h04_80);
    check("t6_rec_count", rec_count, 1);
    check("t6_byte_count", byte_count, 2);

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
